// File: rtl/gcd_pack.sv
// Shared types and defaults for the GCD custom-instruction initiator.
package gcd_pack;

   typedef enum logic [1:0] {IDLE, ASSERT, RUN, RESP} gcd_ci_init_state_t;

   localparam int unsigned GCD_DATA_W  = 32;
   localparam int unsigned GCD_ACK_TMO = 16;
   localparam int unsigned GCD_RUN_TMO = 1024;

   // Counter width able to hold the larger of the two wait limits.
   function automatic int unsigned gcd_tmo_cnt_w(input int unsigned ack, input int unsigned run);
      int unsigned m;
      m = (ack > run) ? ack : run;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/gcd_ci_watchdog.sv
// Wait-cycle counter for the initiator: cleared on state entry, saturating,
// frozen while enable is low.
module gcd_ci_watchdog #(
   parameter int unsigned CNT_W = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic [CNT_W-1:0] limit,
   output logic             expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (enable) begin
         if (clear) begin
            cnt <= '0;
         end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // cnt counts completed wait cycles, so the limit-th cycle is the last one
   assign expired = (limit == '0) || (cnt >= limit - 1'b1);

endmodule

// File: rtl/gcd_ci_initiator.sv
// Initiator side of the multi-cycle custom-instruction handshake.
// Optional wait timeouts are built when GCD_CI_TIMEOUT_EN is defined.
module gcd_ci_initiator
   import gcd_pack::*;
#(
   parameter int unsigned DATA_W  = GCD_DATA_W,
   parameter int unsigned ACK_TMO = GCD_ACK_TMO,
   parameter int unsigned RUN_TMO = GCD_RUN_TMO
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_en,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_err,
   output logic              busy,
   output logic              ci_clk_en,
   output logic              ci_reset,
   output logic              ci_start,
   output logic [DATA_W-1:0] ci_dataa,
   output logic [DATA_W-1:0] ci_datab,
   input  logic              ci_done,
   input  logic [DATA_W-1:0] ci_result
);

   gcd_ci_init_state_t state, state_n;
   logic               start_n;
   logic [DATA_W-1:0]  dataa_n, datab_n, result_n;
   logic               valid_n, err_n;
   logic               expired;

   assign req_ready = (state == IDLE) & ci_done;
   assign busy      = (state != IDLE);
   assign ci_clk_en = clk_en | reset;
   assign ci_reset  = reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ci_start   <= 1'b0;
         ci_dataa   <= '0;
         ci_datab   <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
      end else if (clk_en) begin
         state      <= state_n;
         ci_start   <= start_n;
         ci_dataa   <= dataa_n;
         ci_datab   <= datab_n;
         rsp_valid  <= valid_n;
         rsp_result <= result_n;
         rsp_err    <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      start_n  = ci_start;
      dataa_n  = ci_dataa;
      datab_n  = ci_datab;
      valid_n  = rsp_valid;
      result_n = rsp_result;
      err_n    = rsp_err;
      unique case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               dataa_n = req_a;
               datab_n = req_b;
               start_n = 1'b1;
               state_n = ASSERT;
            end
         end
         ASSERT: begin
            // the slave is edge-triggered: start stays up until done is seen low
            if (!ci_done) begin
               start_n = 1'b0;
               state_n = RUN;
            end else if (expired) begin
               start_n  = 1'b0;
               result_n = '0;
               err_n    = 1'b1;
               valid_n  = 1'b1;
               state_n  = RESP;
            end
         end
         RUN: begin
            start_n = 1'b0;
            if (ci_done) begin
               result_n = ci_result;
               err_n    = 1'b0;
               valid_n  = 1'b1;
               state_n  = RESP;
            end else if (expired) begin
               result_n = '0;
               err_n    = 1'b1;
               valid_n  = 1'b1;
               state_n  = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               valid_n = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

`ifdef GCD_CI_TIMEOUT_EN
   localparam int unsigned CNT_W = gcd_tmo_cnt_w(ACK_TMO, RUN_TMO);

   logic [CNT_W-1:0] tmo_limit;
   logic             tmo_clear;

   assign tmo_limit = (state == RUN) ? CNT_W'(RUN_TMO) : CNT_W'(ACK_TMO);
   assign tmo_clear = (state_n != state);

   gcd_ci_watchdog #(
      .CNT_W(CNT_W)
   ) u_watchdog (
      .clk    (clk),
      .reset  (reset),
      .enable (clk_en),
      .clear  (tmo_clear),
      .limit  (tmo_limit),
      .expired(expired)
   );
`else
   logic unused_tmo;
   assign unused_tmo = ^{ACK_TMO, RUN_TMO};
   assign expired    = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_ci_initiator.sv
// Scoreboard bench for gcd_ci_initiator driving a behavioural GCD slave;
// the stuck-slave scenario checks the GCD_CI_TIMEOUT_EN build when defined.
module tb_gcd_ci_initiator;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ACK_TMO = 16;
   localparam int unsigned RUN_TMO = 1024;

   typedef struct packed {
      logic              err;
      logic [DATA_W-1:0] res;
   } exp_t;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } pair_t;

   logic              clk       = 1'b0;
   logic              reset     = 1'b1;
   logic              clk_en    = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [DATA_W-1:0] req_a     = '0;
   logic [DATA_W-1:0] req_b     = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_err;
   logic              busy;
   logic              ci_clk_en;
   logic              ci_reset;
   logic              ci_start;
   logic [DATA_W-1:0] ci_dataa;
   logic [DATA_W-1:0] ci_datab;
   logic              ci_done;
   logic [DATA_W-1:0] ci_result;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t  exp_q[$];
   pair_t issued_q[$];

   logic ready_mode  = 1'b0;
   logic ready_force = 1'b1;
   logic en_mode     = 1'b0;
   logic en_force    = 1'b1;
   logic stuck       = 1'b0;

   always #5 clk = ~clk;

   gcd_ci_initiator #(
      .DATA_W (DATA_W),
      .ACK_TMO(ACK_TMO),
      .RUN_TMO(RUN_TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clk_en    (clk_en),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_result(rsp_result),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .ci_clk_en (ci_clk_en),
      .ci_reset  (ci_reset),
      .ci_start  (ci_start),
      .ci_dataa  (ci_dataa),
      .ci_datab  (ci_datab),
      .ci_done   (ci_done),
      .ci_result (ci_result)
   );

   // Reference: Euclid by remainder.
   function automatic logic [DATA_W-1:0] ref_gcd(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Slave's own algorithm: binary (Stein) GCD.
   function automatic logic [DATA_W-1:0] stein_gcd(input logic [DATA_W-1:0] a_in, input logic [DATA_W-1:0] b_in);
      logic [DATA_W-1:0] a, b, t;
      int unsigned k;
      a = a_in;
      b = b_in;
      k = 0;
      if (a == 0) return b;
      if (b == 0) return a;
      while (((a | b) & 1) == 0) begin
         a = a >> 1;
         b = b >> 1;
         k++;
      end
      while ((a & 1) == 0) a = a >> 1;
      do begin
         while ((b & 1) == 0) b = b >> 1;
         if (a > b) begin
            t = a;
            a = b;
            b = t;
         end
         b = b - a;
      end while (b != 0);
      return a << k;
   endfunction

   // Behavioural slave: done drops after a start rising edge, returns after 3..8 cycles.
   logic              s_done       = 1'b1;
   logic              s_prev_start = 1'b0;
   int unsigned       s_cnt        = 0;
   logic [DATA_W-1:0] s_a          = '0;
   logic [DATA_W-1:0] s_b          = '0;
   logic [DATA_W-1:0] s_res        = '0;

   always @(posedge clk) begin
      if (ci_reset) begin
         s_done       <= 1'b1;
         s_prev_start <= 1'b0;
         s_cnt        <= 0;
      end else if (ci_clk_en) begin
         s_prev_start <= ci_start;
         if (ci_start && !s_prev_start && !stuck) begin
            s_done <= 1'b0;
            s_a    <= ci_dataa;
            s_b    <= ci_datab;
            s_cnt  <= 3 + $urandom_range(5, 0);
         end else if (s_cnt != 0) begin
            s_cnt <= s_cnt - 1;
            if (s_cnt == 1) begin
               s_done <= 1'b1;
               s_res  <= stein_gcd(s_a, s_b);
            end
         end
      end
   end

   assign ci_done   = stuck ? 1'b1 : s_done;
   assign ci_result = s_res;

   // Per-cycle driver for rsp_ready and clk_en.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         rsp_ready = ready_mode ? 1'($urandom % 2) : ready_force;
         clk_en    = en_mode ? (($urandom % 5) != 0) : en_force;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: samples on the falling edge, between active edges.
   logic [3*DATA_W+4:0] snap, p_snap;
   logic                have_prev = 1'b0;
   logic                p_reset, p_en, p_start, p_done, p_valid, p_hs;
   logic [DATA_W-1:0]   p_result;

   assign snap = {busy, ci_start, ci_dataa, ci_datab, rsp_valid, rsp_result, rsp_err, req_ready};

   always @(negedge clk) begin
      pair_t pr;
      exp_t  ex;
      chk("ci_reset_mirror", ci_reset, reset);
      chk("ci_clk_en_mirror", ci_clk_en, clk_en | reset);
      if (have_prev) begin
         if (p_reset) begin
            chk("rst_busy", busy, 0);
            chk("rst_start", ci_start, 0);
            chk("rst_valid", rsp_valid, 0);
            chk("rst_result", rsp_result, 0);
            chk("rst_err", rsp_err, 0);
            chk("rst_data", {ci_dataa, ci_datab}, 0);
         end else begin
            if (!p_en) chk("freeze", snap, p_snap);
            if (p_start && !ci_start && !rsp_err) chk("start_held_until_ack", p_done, 0);
            if (p_valid && !p_hs) begin
               chk("rsp_hold_valid", rsp_valid, 1);
               chk("rsp_hold_result", rsp_result, p_result);
            end
            if (p_hs) chk("start_gap", ci_start, 0);
            if (!p_start && ci_start) begin
               chk("start_has_req", issued_q.size() != 0, 1);
               if (issued_q.size() != 0) begin
                  pr = issued_q.pop_front();
                  chk("ci_dataa", ci_dataa, pr.a);
                  chk("ci_datab", ci_datab, pr.b);
               end
            end
            if (!p_valid && rsp_valid) chk("rsp_expected", exp_q.size() != 0, 1);
         end
      end
      if (rsp_valid) chk("req_ready_in_resp", req_ready, 0);
      if (rsp_valid && rsp_ready && clk_en && !reset && exp_q.size() != 0) begin
         ex = exp_q.pop_front();
         chk("rsp_result", rsp_result, ex.res);
         chk("rsp_err", rsp_err, ex.err);
      end
      have_prev = 1'b1;
      p_reset   = reset;
      p_en      = clk_en;
      p_start   = ci_start;
      p_done    = ci_done;
      p_valid   = rsp_valid;
      p_result  = rsp_result;
      p_hs      = rsp_valid && rsp_ready && clk_en && !reset;
      p_snap    = snap;
   end

   task automatic present(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
   endtask

   task automatic wait_accept();
      logic  ok;
      exp_t  e;
      pair_t p;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (req_valid && req_ready && clk_en && !reset) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept_wait", ok, 1);
      if (ok) begin
         p.a = req_a;
         p.b = req_b;
         issued_q.push_back(p);
         if (stuck) begin
            e.err = 1'b1;
            e.res = '0;
         end else begin
            e.err = 1'b0;
            e.res = ref_gcd(req_a, req_b);
         end
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic issue(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      present(a, b);
      wait_accept();
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_wait", ok, 1);
   endtask

   task automatic wait_run();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy && !ci_start && !rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("run_wait", ok, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

   initial begin
      int               n_pulse;
      int               n_hi;
      int               n_busy;
      logic             seen;
      logic [DATA_W-1:0] a, b, g;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic operation, single response pulse.
      issue(48, 18);
      n_pulse = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rsp_valid) n_pulse++;
         if (!busy) break;
      end
      chk("basic_rsp_pulses", n_pulse, 1);
      wait_idle();

      // Zero operand with response backpressure and a queued request.
      ready_force = 1'b0;
      issue(0, 7);
      present(35, 14);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("bp_rsp_seen", seen, 1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_result_held", rsp_result, 7);
      end
      ready_force = 1'b1;
      wait_accept();
      wait_idle();

      // Clock-enable gating in the middle of RUN.
      issue(1071, 462);
      wait_run();
      @(posedge clk);
      #1;
      en_force = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      en_force = 1'b1;
      wait_idle();

      // Reset in the middle of RUN: the pending response is dropped.
      issue(100, 75);
      wait_run();
      @(posedge clk);
      #1;
      reset = 1'b1;
      issued_q.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      issue(12, 8);
      wait_idle();

      // Random operands with random backpressure and clock gating.
      ready_mode = 1'b1;
      en_mode    = 1'b1;
      for (int n = 0; n < 30; n++) begin
         case ($urandom % 4)
            0: begin a = $urandom % 64;   b = $urandom % 64;   end
            1: begin a = $urandom % 4096; b = $urandom % 4096; end
            2: begin a = $urandom;        b = $urandom;        end
            default: begin
               g = 1 + $urandom % 50;
               a = g * (1 + $urandom % 200);
               b = g * (1 + $urandom % 200);
            end
         endcase
         issue(a, b);
      end
      wait_idle();
      ready_mode = 1'b0;
      en_mode    = 1'b0;
      @(posedge clk);
      #1;

      // Slave whose done never falls.
      stuck = 1'b1;
`ifdef GCD_CI_TIMEOUT_EN
      issue(9, 6);
      n_hi = 0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1'b1;
            break;
         end
         if (ci_start) n_hi++;
      end
      chk("tmo_rsp_seen", seen, 1);
      chk("tmo_ack_cycles", n_hi, ACK_TMO);
      chk("tmo_start_low", ci_start, 0);
      wait_idle();
      stuck = 1'b0;
`else
      issue(9, 6);
      n_busy = 0;
      repeat (2000) begin
         @(negedge clk);
         if (busy) n_busy++;
      end
      chk("stuck_busy_cycles", n_busy, 2000);
      @(posedge clk);
      #1;
      reset = 1'b1;
      issued_q.delete();
      exp_q.delete();
      stuck = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
`endif

      issue(270, 192);
      wait_idle();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
